// File: rtl/baud_gen_nco.sv
// baud_gen_nco: phase-accumulator baud generator for the UART TX/RX engines.
// Every accumulator overflow produces one oversample tick. A counter of those
// ticks marks the bit boundary (baud_tick) and the bit centre (mid_tick).
// The increment can be changed at runtime without disturbing the phase, and
// the phase can be restarted so the receiver can line up on a start-bit edge.
module baud_gen_nco #(
    parameter int     CLK_FREQ    = 10000000,
    parameter int     BAUD        = 115200,
    parameter int     OVERSAMPLE  = 16,
    parameter int     ACC_W       = 24,
    parameter longint DEFAULT_INC = longint'(real'(BAUD) * real'(OVERSAMPLE) *
                                             (2.0 ** ACC_W) / real'(CLK_FREQ)),
    localparam int    OS_W        = ($clog2(OVERSAMPLE) > 1) ? $clog2(OVERSAMPLE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             phase_clear,
    input  logic             inc_load,
    input  logic [ACC_W-1:0] inc_value,
    output logic [ACC_W-1:0] inc_active,
    output logic [OS_W-1:0]  os_count,
    output logic             os_tick,
    output logic             baud_tick,
    output logic             mid_tick
);

    // A zero or full-scale default increment cannot produce a usable rate.
    if (DEFAULT_INC <= 0 || DEFAULT_INC >= (longint'(1) << ACC_W)) begin : g_bad_inc
        $fatal(1, "baud_gen_nco: DEFAULT_INC out of range");
    end
    if (OVERSAMPLE < 2) begin : g_bad_os
        $fatal(1, "baud_gen_nco: OVERSAMPLE must be at least 2");
    end

    localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(DEFAULT_INC);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_PREMID = OS_W'(OVERSAMPLE / 2 - 1);

    // Next oversample index, wrapping at the end of the bit.
    function automatic logic [OS_W-1:0] os_wrap(input logic [OS_W-1:0] cnt);
        os_wrap = (cnt == OS_LAST) ? '0 : cnt + 1'b1;
    endfunction

    logic [ACC_W-1:0] inc_p0;
    logic [ACC_W-1:0] acc_p0;
    logic [OS_W-1:0]  os_cnt_p0;
    logic             os_tick_p1;
    logic             baud_tick_p1;
    logic             mid_tick_p1;
    logic [ACC_W:0]   sum;
    logic             carry;

    // Stage p0 -> p1: one extra bit of the sum is the overflow carry.
    always_comb begin
        sum   = {1'b0, acc_p0} + {1'b0, inc_p0};
        carry = sum[ACC_W];
    end

    // Increment register; the add on a load edge still uses the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_p0 <= INC_RST;
        end else if (inc_load) begin
            inc_p0 <= inc_value;
        end
    end

    // Phase accumulator, oversample counter and registered tick outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p0       <= '0;
            os_cnt_p0    <= '0;
            os_tick_p1   <= 1'b0;
            baud_tick_p1 <= 1'b0;
            mid_tick_p1  <= 1'b0;
        end else if (phase_clear) begin
            acc_p0       <= '0;
            os_cnt_p0    <= '0;
            os_tick_p1   <= 1'b0;
            baud_tick_p1 <= 1'b0;
            mid_tick_p1  <= 1'b0;
        end else if (enable) begin
            acc_p0       <= sum[ACC_W-1:0];
            os_tick_p1   <= carry;
            baud_tick_p1 <= carry && (os_cnt_p0 == OS_LAST);
            mid_tick_p1  <= carry && (os_cnt_p0 == OS_PREMID);
            if (carry) begin
                os_cnt_p0 <= os_wrap(os_cnt_p0);
            end
        end else begin
            os_tick_p1   <= 1'b0;
            baud_tick_p1 <= 1'b0;
            mid_tick_p1  <= 1'b0;
        end
    end

    assign inc_active = inc_p0;
    assign os_count   = os_cnt_p0;
    assign os_tick    = os_tick_p1;
    assign baud_tick  = baud_tick_p1;
    assign mid_tick   = mid_tick_p1;

endmodule

// File: doc/baud_gen_nco.md
Name: baud_gen_nco

Overview:
- Parametrised phase-accumulator (NCO) baud generator, successor to the fixed-increment single-output generator.
- Produces a single-cycle oversample tick, a bit-rate tick and a mid-bit sample tick for UART TX/RX.
- Increment is runtime-programmable; phase is restartable so RX can align to a start-bit edge.
- Sits between the clock domain root and the UART TX/RX engines; all outputs are registered.

Parameters:
- CLK_FREQ, 10000000, input clock frequency in Hz.
- BAUD, 115200, reset-default bit rate in baud.
- OVERSAMPLE, 16, oversample ticks per bit; must be ≥2.
- ACC_W, 24, accumulator width in bits.
- DEFAULT_INC, round(BAUD*OVERSAMPLE*2^ACC_W/CLK_FREQ), reset value of the increment, computed in real arithmetic; elaboration fails fatally if it is 0 or ≥2^ACC_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  advance the accumulator when high.
- phase_clear  in  1  synchronous restart of phase.
- inc_load  in  1  load inc_value into the increment register.
- inc_value  in  ACC_W  new increment.
- inc_active  out  ACC_W  current increment register.
- os_count  out  max(1,$clog2(OVERSAMPLE))  oversample index within the bit, 0..OVERSAMPLE-1.
- os_tick  out  1  one-cycle pulse per accumulator overflow.
- baud_tick  out  1  one-cycle pulse when os_count wraps OVERSAMPLE-1→0.
- mid_tick  out  1  one-cycle pulse when os_count enters OVERSAMPLE/2 (floor).

Behaviour:
- Reset (async, any time, including mid-bit):
  - acc=0, os_count=0, os_tick=baud_tick=mid_tick=0, inc_active=DEFAULT_INC.
- Each rising edge, in priority order:
  1. phase_clear=1: acc←0, os_count←0, all ticks←0; inc register is untouched.
  2. enable=1:
     - {c,acc}←acc+inc_active, ACC_W+1-bit sum; acc wraps modulo 2^ACC_W.
     - os_tick←c.
     - If c: os_count←(os_count==OVERSAMPLE-1)?0:os_count+1.
     - baud_tick←c && os_count==OVERSAMPLE-1.
     - mid_tick←c && os_count==OVERSAMPLE/2-1.
  3. enable=0: acc and os_count hold; all ticks←0.
- Tick latency: a tick is high in the cycle after the edge whose add overflowed. Ticks are never high for 2 consecutive cycles unless inc_active ≥2^(ACC_W-1).
- baud_tick and the os_tick of the wrap are coincident. mid_tick is coincident with one os_tick.
- inc_load is independent of phase_clear and enable:
  - inc_active←inc_value on that edge.
  - The add on the same edge uses the old value; the new value applies from the next edge.
  - acc is not cleared, so the rate changes glitch-free.
- inc_active=0 (loaded): acc freezes and no ticks are generated; not an error.
- phase_clear and inc_load on the same edge: both take effect.
- Long-run os_tick frequency is exactly CLK_FREQ*inc_active/2^ACC_W. Over N·2^ACC_W enabled cycles from acc=0, exactly N·inc_active os_ticks occur.

Test Plan:
- Default rate, ACC_W=24, OS=16, 10 MHz/115200: expect inc_active=3092376 after reset. Over 2^20 enabled cycles from reset, expect exactly 193273 os_ticks, 12079 baud_ticks and 12080 mid_ticks, never 2 consecutive.
- ACC_W=8, OS=4: load inc=64 then enable. Expect os_tick every 4th cycle, os_count 0→1→2→3→0, baud_tick every 16 cycles coincident with os_count returning to 0, mid_tick 8 cycles offset from baud_tick.
- ACC_W=8, OS=4, inc=64, run 6 cycles:
  - Assert phase_clear for 1 edge while enable stays high.
  - Expect all ticks 0 and os_count=0 that cycle.
  - First os_tick exactly 4 cycles after the clear edge; baud_tick 16 cycles after it.
- Rate change mid-stream: inc 64→128 via inc_load with enable high.
  - The same-edge add uses 64.
  - Tick spacing becomes 2 cycles with no dropped or double tick at the change.
  - inc_active reads 128 the cycle after.
- enable low for 10 cycles mid-bit: no ticks, and acc/os_count are unchanged on resume. Tick spacing after resume continues the pre-pause phase.
- reset asserted asynchronously between edges mid-bit: outputs go to reset values immediately, and inc_active returns to DEFAULT_INC. Loading inc_value=0 afterwards: no ticks for 100 cycles.
